// File: rtl/seg7_scan_mux_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux_if
// Bundles the display-side signals of the 4-digit scan multiplexer.
//   master : drives value / dp_mask / en_mask / lz_en, observes the scan outputs
//   slave  : the scanner itself
// Signals:
//   value[15:0]    display value, digit d = value[4d+3:4d] (digit 0 rightmost)
//   dp_mask[3:0]   decimal point request per digit, active-high
//   en_mask[3:0]   digit enable per digit, active-high (used live)
//   lz_en          leading-zero suppression enable
//   hex_out[3:0]   nibble for the downstream hex-to-7-segment decoder
//   an[3:0]        anode drive, active-low
//   dp_n           decimal point segment, active-low
//   digit_idx[1:0] digit currently scanned
//   frame_tick     one-cycle pulse when a new snapshot is taken
// ---------------------------------------------------------------------------
interface seg7_scan_mux_if;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic [3:0]  en_mask;
   logic        lz_en;
   logic [3:0]  hex_out;
   logic [3:0]  an;
   logic        dp_n;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   modport master (
      output value, dp_mask, en_mask, lz_en,
      input  hex_out, an, dp_n, digit_idx, frame_tick
   );

   modport slave (
      input  value, dp_mask, en_mask, lz_en,
      output hex_out, an, dp_n, digit_idx, frame_tick
   );
endinterface

// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexed scanner for a 4-digit common-anode display. Each digit
// owns a slot of DIV clocks; the first GUARD clocks of every slot keep all
// anodes off to suppress ghosting. value / dp_mask / lz_en are snapshotted
// once per frame (on entry to digit 0) so a frame never mixes old and new
// data; en_mask is applied live.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  seg7_scan_mux_if.slave (inputs value/dp_mask/en_mask/lz_en,
//        outputs hex_out/an/dp_n/digit_idx/frame_tick)
// Parameters:
//   DIV   clocks per digit slot (>= 2)
//   GUARD blank clocks at the start of each slot (0 <= GUARD < DIV)
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
   parameter int DIV   = 100000,
   parameter int GUARD = 2000
) (
   input  logic              clk,
   input  logic              rst,
   seg7_scan_mux_if.slave    bus
);

   localparam int              CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] GRD_END = CNT_W'(GUARD);

   logic [CNT_W-1:0] cnt_p0;
   logic [1:0]       idx_p0;
   logic [15:0]      snap_val_p0;
   logic [3:0]       snap_dp_p0;
   logic             snap_lz_p0;

   logic [3:0]       hex_p1;
   logic [3:0]       an_p1;
   logic             dpn_p1;
   logic             tick_p1;

   logic             slot_end;
   logic             frame_end;
   logic [3:0]       blank;
   logic             lit;
   logic [3:0]       nib;
   logic [3:0]       an_nxt;

   // ---- stage p0: slot position decode and lighting decision ----
   always_comb begin
      slot_end  = (cnt_p0 == CNT_MAX);
      frame_end = slot_end && (idx_p0 == 2'd3);

      // A digit is blanked when it and every digit above it are zero;
      // digit 0 always shows so "0" still appears for an all-zero value.
      blank    = 4'b0000;
      blank[3] = (snap_val_p0[15:12] == 4'h0);
      blank[2] = blank[3] && (snap_val_p0[11:8] == 4'h0);
      blank[1] = blank[2] && (snap_val_p0[7:4] == 4'h0);
      blank[0] = 1'b0;
      blank    = blank & {4{snap_lz_p0}};

      nib    = snap_val_p0[{idx_p0, 2'b00} +: 4];
      lit    = (cnt_p0 >= GRD_END) && bus.en_mask[idx_p0] && !blank[idx_p0];
      an_nxt = lit ? (4'hF ^ (4'b0001 << idx_p0)) : 4'hF;
   end

   // ---- stage p0 -> p1: counters, snapshot and registered outputs ----
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0      <= '0;
         idx_p0      <= 2'd0;
         snap_val_p0 <= 16'h0000;
         snap_dp_p0  <= 4'h0;
         snap_lz_p0  <= 1'b0;
         hex_p1      <= 4'h0;
         an_p1       <= 4'hF;
         dpn_p1      <= 1'b1;
         tick_p1     <= 1'b0;
      end else begin
         cnt_p0 <= slot_end ? '0 : cnt_p0 + CNT_W'(1);
         if (slot_end) begin
            idx_p0 <= idx_p0 + 2'd1;
         end
         // The snapshot lands together with the wrap into digit 0, so the
         // whole next frame is drawn from one consistent capture.
         if (frame_end) begin
            snap_val_p0 <= bus.value;
            snap_dp_p0  <= bus.dp_mask;
            snap_lz_p0  <= bus.lz_en;
         end
         hex_p1  <= nib;
         an_p1   <= an_nxt;
         dpn_p1  <= !(lit && snap_dp_p0[idx_p0]);
         tick_p1 <= frame_end;
      end
   end

   assign bus.hex_out    = hex_p1;
   assign bus.an         = an_p1;
   assign bus.dp_n       = dpn_p1;
   assign bus.digit_idx  = idx_p0;
   assign bus.frame_tick = tick_p1;

endmodule
